// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: receives a SYNC/COUNT/(LO,HI)* frame and writes each
// instruction into the instruction RAM, holding the CPU in reset until the frame completes.
module uart_prog_loader #(
  parameter int          CLK_FREQ = 100000000,
  parameter int          BAUD     = 115200,
  parameter int          N        = 10,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  SYNC     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_LO, S_HI, S_WRITE, S_DONE} state_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  state_t           state_q, state_d;
  logic [8:0]       count_q, count_d;
  logic [7:0]       lo_q, lo_d;
  logic             wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0]     wr_data_q, wr_data_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_word;

  // Byte receiver: start bit re-checked at mid-bit, then every bit sampled at its centre.
  always_comb begin
    rx_state_d   = rx_state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          baud_cnt_d = '0;
        end
      end
      RX_START: begin
        if (baud_cnt_q == CNT_W'(HALF - 1)) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == CNT_W'(CPB - 1)) begin
          baud_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == CNT_W'(CPB - 1)) begin
          baud_cnt_d   = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign last_word = ((9'(wr_addr_q) + 9'd1) == count_q);

  // Frame FSM; a framing error past SYNC aborts the frame but keeps the CPU held.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lo_d       = lo_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (byte_valid_q && shift_q == SYNC) begin
          state_d    = S_COUNT;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          wr_addr_d  = '0;
        end
      end
      S_COUNT, S_LO, S_HI: begin
        if (frame_err_q) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (byte_valid_q) begin
          if (state_q == S_COUNT) begin
            if (shift_q == 8'd0 || {1'b0, shift_q} > 9'(DEPTH)) begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              count_d = {1'b0, shift_q};
              state_d = S_LO;
            end
          end else if (state_q == S_LO) begin
            lo_d    = shift_q;
            state_d = S_HI;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = {shift_q[N-9:0], lo_q};
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cpu_hold_d = 1'b0;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          state_d   = S_LO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= S_IDLE;
      count_q      <= '0;
      lo_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      count_q      <= count_d;
      lo_q         <= lo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: expected RAM writes are queued as frames are sent
// and compared by a monitor whenever the loader strobes wr_en.
module tb_uart_prog_loader;
  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [9:0] wr_data;
  logic       cpu_hold, busy, done, err;

  typedef struct {
    logic [3:0] addr;
    logic [9:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  max_addr = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLK_FREQ(1000000), .BAUD(100000), .N(10), .ADDR_W(4), .SYNC(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      wr_t e;
      wr_cnt++;
      if (32'(wr_addr) > 32'(max_addr)) max_addr = int'(wr_addr);
      $display("write addr=%0h data=%0h", wr_addr, wr_data);
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (!reset && done) begin
      done_cnt++;
      $display("done pulse #%0d", done_cnt);
      check("hold_at_done", 32'(cpu_hold), 32'd0);
      check("busy_at_done", 32'(busy), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [9:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_reset_values();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    // Reset and idle line
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("idle_hold", 32'(cpu_hold), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("idle_writes", 32'(wr_cnt), 32'd0);

    // Two-word frame
    push_wr(4'd0, 10'h134);
    push_wr(4'd1, 10'h27F);
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("sync_busy", 32'(busy), 32'd1);
    check("sync_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_done(1);
    check("f1_writes", 32'(wr_cnt), 32'd2);
    check("f1_hold", 32'(cpu_hold), 32'd0);
    check("f1_busy", 32'(busy), 32'd0);

    // Full-depth frame
    max_addr = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    for (int i = 0; i < 16; i++) begin
      push_wr(4'(i), 10'(i));
      send_byte(8'(i), 1'b1);
      send_byte(8'h00, 1'b1);
    end
    wait_done(2);
    check("f2_writes", 32'(wr_cnt), 32'd18);
    check("f2_max_addr", 32'(max_addr), 32'd15);
    check("f2_queue", 32'(exp_q.size()), 32'd0);

    // Zero count is an error; a following frame clears it
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clk);
    check("cnt0_err", 32'(err), 32'd1);
    check("cnt0_busy", 32'(busy), 32'd0);
    check("cnt0_hold", 32'(cpu_hold), 32'd1);
    check("cnt0_writes", 32'(wr_cnt), 32'd18);
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("resync_err", 32'(err), 32'd0);
    push_wr(4'd0, 10'h00F);
    send_byte(8'h01, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_done(3);

    // Framing error mid-frame, then a glitch that must not form a byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    @(negedge clk);
    check("ferr_err", 32'(err), 32'd1);
    check("ferr_busy", 32'(busy), 32'd0);
    check("ferr_hold", 32'(cpu_hold), 32'd1);
    check("ferr_writes", 32'(wr_cnt), 32'd19);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    @(posedge clk);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    push_wr(4'd0, 10'h012);
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_done(4);
    check("glitch_writes", 32'(wr_cnt), 32'd20);

    // Reset in the middle of the second word's HI byte
    push_wr(4'd0, 10'h011);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h22, 1'b1);
    @(posedge clk);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (2 * CPB + 5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_writes", 32'(wr_cnt), 32'd21);
    check("rst_queue", 32'(exp_q.size()), 32'd0);
    check("rst_busy_after", 32'(busy), 32'd0);
    push_wr(4'd0, 10'h344);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h03, 1'b1);
    wait_done(5);
    check("final_writes", 32'(wr_cnt), 32'd22);
    check("final_hold", 32'(cpu_hold), 32'd0);
    check("final_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader: receives a framed instruction image over UART (8N1) and writes it word-by-word into the instruction memory that the k2 processor fetches from.
- Holds the CPU in reset while loading, then releases it.
- It is the write-side counterpart of the instruction ROM read path, and sits between the board RX pin, the instruction RAM write port and the CPU reset.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
- N, 10, instruction width. Valid range is 9..16.
- ADDR_W, 4, instruction memory address width. Depth is 2**ADDR_W.
- SYNC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  UART serial input. Asynchronous to clk; idle level is 1.
- wr_en  out  1  one-cycle write strobe to instruction RAM.
- wr_addr  out  ADDR_W  instruction RAM write address.
- wr_data  out  N  instruction RAM write data.
- cpu_hold  out  1  1 = hold the processor in reset.
- busy  out  1  1 while a frame is in progress (past SYNC).
- done  out  1  one-cycle pulse when a frame completes successfully.
- err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
  - cpu_hold=1.
  - FSM=IDLE. Both rx synchroniser flops = 1.
- rx input conditioning: passes through a 2-flop synchroniser. All sampling uses the synchronised signal.
- Byte receiver:
  - Start is detected on a falling edge of the synchronised rx.
  - Wait CLKS_PER_BIT/2 clocks, then re-sample. If rx is 1, it is a false start: return to idle, no error.
  - Sample 8 data bits, LSB first, each CLKS_PER_BIT apart.
  - Sample the stop bit one CLKS_PER_BIT later.
  - Stop=1: byte is valid, one-cycle internal byte_valid. Stop=0: framing error.
- Frame format: SYNC byte, then COUNT byte, then COUNT pairs of (LO byte, HI byte).
  - Instruction = {HI[N-9:0], LO}. HI bits above N-9 are ignored.
- FSM states: IDLE, COUNT, LO, HI, WRITE, DONE.
  - IDLE: on byte==SYNC, go to COUNT and set cpu_hold=1, busy=1, err=0, wr_addr=0. Any other byte is discarded.
  - COUNT: if byte is 0 or greater than 2**ADDR_W, set err=1, busy=0 and go to IDLE. Otherwise latch the count and go to LO.
  - LO: latch the byte, go to HI.
  - HI: latch the byte, go to WRITE.
  - WRITE: a single cycle with wr_en=1 and wr_data/wr_addr valid. This is exactly one clock after HI's byte_valid. Then:
    - if this is the last word, go to DONE;
    - otherwise wr_addr+1 and go to LO.
  - DONE: a single cycle with done=1, busy=0, cpu_hold=0, then go to IDLE.
- cpu_hold stays 0 until the next SYNC is accepted. After an error it stays 1.
- Framing error in any state other than IDLE: err=1, busy=0, abort to IDLE. Words already written stay in RAM and cpu_hold stays 1.
- Framing error in IDLE: the byte is ignored and err is unchanged.
- SYNC seen in any state other than IDLE is treated as data, not as a restart.
- wr_addr never wraps within a frame, because COUNT ≤ depth.
- Assertion of reset at any time, including mid-frame or mid-byte: immediately returns to reset values.
- err clears only when a new SYNC is accepted, or on reset.

Test Plan (bench parameters CLK_FREQ=1000000, BAUD=100000, so 10 clocks/bit; N=10, ADDR_W=4):
- Reset then idle rx=1 for 200 clocks -> cpu_hold=1, wr_en never 1, busy=0, err=0.
- Send A5, 02, 34, 01, 7F, 02 -> wr_en pulses at addr 0 with data 10'h134, then addr 1 with data 10'h27F. Then done pulses once, cpu_hold falls to 0 in the same cycle, busy=0.
- Send A5, 10, then 16 pairs (i, 00) -> 16 writes at addr 0..15 with data i. done=1, and wr_addr never exceeds 15.
- Send A5, 00 -> err=1, busy=0, no write, cpu_hold=1. Then send a valid frame -> err clears on A5 and the load completes.
- Send A5, 01, 55, then a byte with stop bit 0 -> err=1, no wr_en, FSM back in IDLE. A 3-clock rx low glitch -> no byte received.
- Assert reset mid-HI-byte of a 2-word frame -> all outputs return to reset values and no write occurs. A following valid frame loads correctly.
